// File: rtl/pq_sched_pkg.sv
// Shared types and helpers for the priority-queue access scheduler.
//   op_e    : client request opcode (push / pop / replace, 00 reserved)
//   state_e : scheduler FSM states
//   rr_next : round-robin pointer advance with wrap at n
package pq_sched_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    SETTLE = 2'b10
  } state_e;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   eligible    : per-requester eligibility mask
//   ptr         : index that gets highest priority this cycle
//   grant       : one-hot winner (all zero when nothing is eligible)
//   grant_idx   : binary index of the winner
//   grant_valid : some requester won
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  // Walk offsets from farthest to nearest so the requester closest to ptr
  // overwrites any earlier candidate and ends up as the winner.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (eligible[idx]) begin
        grant       = '0;
        grant[idx]  = 1'b1;
        grant_idx   = IW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pq_access_scheduler.sv
// Shares one max-at-head priority queue between NUM_CLIENTS requesters.
// One request at a time is granted round-robin, driven to the queue for a
// single cycle, and the pre-op head is returned for pop/replace. After each
// op the scheduler idles SETTLE_CYCLES so the sorter can restore the head.
// Ports:
//   i_CLK, i_RSTn                    clock, async active-low reset
//   i_req_valid/op/data              per-client request (flattened vectors)
//   o_req_ready                      one-hot grant, combinational, IDLE only
//   o_rsp_valid/id/data              one-cycle head-value response
//   o_q_wrt/o_q_read/o_q_data        registered queue controls
//   i_q_full/i_q_empty/i_q_data      queue status and head value
module pq_access_scheduler
  import pq_sched_pkg::*;
#(
  parameter int NUM_CLIENTS   = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int ENQ_ENA       = 1
) (
  input  logic                              i_CLK,
  input  logic                              i_RSTn,
  input  logic [NUM_CLIENTS-1:0]            i_req_valid,
  input  logic [NUM_CLIENTS*2-1:0]          i_req_op,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_CLIENTS-1:0]            o_req_ready,
  output logic                              o_rsp_valid,
  output logic [$clog2(NUM_CLIENTS)-1:0]    o_rsp_id,
  output logic [DATA_WIDTH-1:0]             o_rsp_data,
  output logic                              o_q_wrt,
  output logic                              o_q_read,
  output logic [DATA_WIDTH-1:0]             o_q_data,
  input  logic                              i_q_full,
  input  logic                              i_q_empty,
  input  logic [DATA_WIDTH-1:0]             i_q_data
);

  localparam int IDW  = $clog2(NUM_CLIENTS);
  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e                 state_reg, state_next;
  logic [IDW-1:0]         rr_ptr_reg;
  logic [CNTW-1:0]        settle_cnt_reg;
  op_e                    op_reg;
  logic [IDW-1:0]         id_reg;
  logic                   q_wrt_reg, q_read_reg;
  logic [DATA_WIDTH-1:0]  q_data_reg;
  logic                   rsp_valid_reg;
  logic [IDW-1:0]         rsp_id_reg;
  logic [DATA_WIDTH-1:0]  rsp_data_reg;

  logic [NUM_CLIENTS-1:0] eligible;
  logic [NUM_CLIENTS-1:0] grant;
  logic [IDW-1:0]         grant_idx;
  logic                   grant_valid;
  logic                   handshake;
  op_e                    sel_op;
  logic [DATA_WIDTH-1:0]  sel_data;

  // Ineligible requests are simply not granted; they stay pending at the client.
  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_elig
    op_e op_w;
    assign op_w = op_e'(i_req_op[gi*2 +: 2]);
    assign eligible[gi] = i_req_valid[gi] &&
      ((op_w == OP_PUSH && ENQ_ENA != 0 && !i_q_full) ||
       ((op_w == OP_POP || op_w == OP_REPLACE) && !i_q_empty));
  end

  rr_arbiter #(.N(NUM_CLIENTS), .IW(IDW)) u_arb (
    .eligible    (eligible),
    .ptr         (rr_ptr_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Gating with i_RSTn keeps the combinational grant quiet while in reset.
  assign handshake   = (state_reg == IDLE) && grant_valid && i_RSTn;
  assign o_req_ready = handshake ? grant : '0;
  assign sel_op      = op_e'(i_req_op[int'(grant_idx)*2 +: 2]);
  assign sel_data    = i_req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = ISSUE;
      ISSUE:   state_next = (SETTLE_CYCLES > 0) ? SETTLE : IDLE;
      SETTLE:  if (settle_cnt_reg == CNTW'(SETTLE_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      rr_ptr_reg     <= '0;
      settle_cnt_reg <= '0;
      op_reg         <= OP_NOP;
      id_reg         <= '0;
      q_wrt_reg      <= 1'b0;
      q_read_reg     <= 1'b0;
      q_data_reg     <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_data_reg   <= '0;
    end else begin
      // Queue controls are high only for the single ISSUE cycle that
      // follows the handshake.
      if (handshake) begin
        op_reg     <= sel_op;
        id_reg     <= grant_idx;
        rr_ptr_reg <= IDW'(rr_next(int'(grant_idx), NUM_CLIENTS));
        q_wrt_reg  <= (sel_op == OP_PUSH) || (sel_op == OP_REPLACE);
        q_read_reg <= (sel_op == OP_POP)  || (sel_op == OP_REPLACE);
        q_data_reg <= (sel_op == OP_POP) ? '0 : sel_data;
      end else begin
        q_wrt_reg  <= 1'b0;
        q_read_reg <= 1'b0;
        q_data_reg <= '0;
      end

      if (state_reg == ISSUE)       settle_cnt_reg <= '0;
      else if (state_reg == SETTLE) settle_cnt_reg <= settle_cnt_reg + 1'b1;

      // The head is sampled during ISSUE, before the queue applies the op.
      rsp_valid_reg <= (state_reg == ISSUE) &&
                       (op_reg == OP_POP || op_reg == OP_REPLACE);
      if (state_reg == ISSUE) begin
        rsp_id_reg   <= id_reg;
        rsp_data_reg <= i_q_data;
      end
    end
  end

  assign o_q_wrt     = q_wrt_reg;
  assign o_q_read    = q_read_reg;
  assign o_q_data    = q_data_reg;
  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_id    = rsp_id_reg;
  assign o_rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_pq_access_scheduler.sv
// Directed bench for pq_access_scheduler (4 clients, 16-bit data, settle 2).
// The queue side is driven by hand; expected values are written inline.
module tb_pq_access_scheduler;

  logic        i_CLK = 1'b0;
  logic        i_RSTn = 1'b0;
  logic [3:0]  i_req_valid = '0;
  logic [7:0]  i_req_op = '0;
  logic [63:0] i_req_data = '0;
  logic [3:0]  o_req_ready;
  logic        o_rsp_valid;
  logic [1:0]  o_rsp_id;
  logic [15:0] o_rsp_data;
  logic        o_q_wrt, o_q_read;
  logic [15:0] o_q_data;
  logic        i_q_full = 1'b0;
  logic        i_q_empty = 1'b1;
  logic [15:0] i_q_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_CLK = ~i_CLK;

  pq_access_scheduler #(
    .NUM_CLIENTS(4), .DATA_WIDTH(16), .SETTLE_CYCLES(2), .ENQ_ENA(1)
  ) dut (
    .i_CLK       (i_CLK),
    .i_RSTn      (i_RSTn),
    .i_req_valid (i_req_valid),
    .i_req_op    (i_req_op),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_data  (o_rsp_data),
    .o_q_wrt     (o_q_wrt),
    .o_q_read    (o_q_read),
    .o_q_data    (o_q_data),
    .i_q_full    (i_q_full),
    .i_q_empty   (i_q_empty),
    .i_q_data    (i_q_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic set_req(input int c, input logic v, input logic [1:0] op, input logic [15:0] d);
    i_req_valid[c]      = v;
    i_req_op[c*2 +: 2]  = op;
    i_req_data[c*16 +: 16] = d;
  endtask

  task automatic clear_reqs();
    i_req_valid = '0;
    i_req_op    = '0;
    i_req_data  = '0;
  endtask

  // Returns just after reset is released, on a falling edge.
  task automatic do_reset();
    i_RSTn = 1'b0;
    repeat (2) @(negedge i_CLK);
    i_RSTn = 1'b1;
  endtask

  int gr[$];
  int iss[$];

  initial begin
    // 1: reset with a pending push from client0
    i_q_empty = 1'b1; i_q_full = 1'b0; i_q_data = '0;
    set_req(0, 1'b1, 2'b01, 16'h0005);
    repeat (2) @(negedge i_CLK);
    #1;
    check("t1_rst_ready", 32'(o_req_ready), 32'h0);
    check("t1_rst_wrt",   32'(o_q_wrt),     32'h0);
    check("t1_rst_read",  32'(o_q_read),    32'h0);
    check("t1_rst_rsp",   32'(o_rsp_valid), 32'h0);
    check("t1_rst_qdata", 32'(o_q_data),    32'h0);
    @(negedge i_CLK);
    i_RSTn = 1'b1;
    #1;
    check("t1_ready",   32'(o_req_ready), 32'h1);
    @(negedge i_CLK);
    check("t1_wrt",     32'(o_q_wrt),  32'h1);
    check("t1_read",    32'(o_q_read), 32'h0);
    check("t1_qdata",   32'(o_q_data), 32'h5);
    check("t1_ready_off", 32'(o_req_ready), 32'h0);
    clear_reqs();
    @(negedge i_CLK);
    check("t1_no_rsp",  32'(o_rsp_valid), 32'h0);
    check("t1_wrt_off", 32'(o_q_wrt),     32'h0);

    // 2: all four clients push continuously
    clear_reqs();
    i_q_empty = 1'b1; i_q_full = 1'b0;
    for (int c = 0; c < 4; c++) set_req(c, 1'b1, 2'b01, 16'(16'h10 + c));
    do_reset();
    for (int k = 0; k < 20; k++) begin
      #1;
      if (o_req_ready != 0) begin
        check("t2_onehot", 32'($countones(o_req_ready)), 32'h1);
        for (int c = 0; c < 4; c++) if (o_req_ready[c]) gr.push_back(c);
      end
      if (o_q_wrt) begin
        iss.push_back(k);
        check("t2_read0", 32'(o_q_read), 32'h0);
        if (gr.size() > 0) check("t2_qdata", 32'(o_q_data), 32'(16'h10 + gr[gr.size()-1]));
      end
      @(negedge i_CLK);
    end
    check("t2_ngrant", 32'(gr.size()),  32'd5);
    check("t2_nissue", 32'(iss.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < gr.size()) check($sformatf("t2_grant%0d", i), 32'(gr[i]), 32'(i % 4));
    for (int i = 1; i < 5; i++)
      if (i < iss.size()) check($sformatf("t2_gap%0d", i), 32'(iss[i] - iss[i-1]), 32'd4);

    // 3: pop returns the pre-op head
    clear_reqs();
    i_q_empty = 1'b0; i_q_data = 16'h0030;
    set_req(2, 1'b1, 2'b10, 16'h0);
    do_reset();
    #1;
    check("t3_ready", 32'(o_req_ready), 32'h4);
    @(negedge i_CLK);
    check("t3_read",  32'(o_q_read), 32'h1);
    check("t3_wrt",   32'(o_q_wrt),  32'h0);
    check("t3_qdata", 32'(o_q_data), 32'h0);
    check("t3_rsp_early", 32'(o_rsp_valid), 32'h0);
    clear_reqs();
    @(negedge i_CLK);
    check("t3_rsp_valid", 32'(o_rsp_valid), 32'h1);
    check("t3_rsp_id",    32'(o_rsp_id),    32'h2);
    check("t3_rsp_data",  32'(o_rsp_data),  32'h30);
    check("t3_read_off",  32'(o_q_read),    32'h0);
    @(negedge i_CLK);
    check("t3_rsp_pulse", 32'(o_rsp_valid), 32'h0);

    // 4: pop blocked by empty, push goes first, then the pop
    clear_reqs();
    i_q_empty = 1'b1; i_q_data = '0;
    set_req(1, 1'b1, 2'b10, 16'h0);
    set_req(3, 1'b1, 2'b01, 16'h0007);
    do_reset();
    #1;
    check("t4_ready_push", 32'(o_req_ready), 32'h8);
    @(negedge i_CLK);
    check("t4_wrt",   32'(o_q_wrt),  32'h1);
    check("t4_qdata", 32'(o_q_data), 32'h7);
    set_req(3, 1'b0, 2'b00, 16'h0);
    i_q_empty = 1'b0; i_q_data = 16'h0007;
    @(negedge i_CLK);
    #1;
    check("t4_settle_ready", 32'(o_req_ready), 32'h0);
    @(negedge i_CLK);
    @(negedge i_CLK);
    #1;
    check("t4_ready_pop", 32'(o_req_ready), 32'h2);
    @(negedge i_CLK);
    check("t4_read", 32'(o_q_read), 32'h1);
    check("t4_wrt0", 32'(o_q_wrt),  32'h0);
    clear_reqs();
    @(negedge i_CLK);
    check("t4_rsp_valid", 32'(o_rsp_valid), 32'h1);
    check("t4_rsp_id",    32'(o_rsp_id),    32'h1);
    check("t4_rsp_data",  32'(o_rsp_data),  32'h7);

    // 5: queue full blocks push, replace still goes
    clear_reqs();
    i_q_full = 1'b1; i_q_empty = 1'b0; i_q_data = 16'h0009;
    set_req(0, 1'b1, 2'b01, 16'h0099);
    set_req(1, 1'b1, 2'b11, 16'h0002);
    do_reset();
    #1;
    check("t5_ready", 32'(o_req_ready), 32'h2);
    @(negedge i_CLK);
    check("t5_wrt",   32'(o_q_wrt),  32'h1);
    check("t5_read",  32'(o_q_read), 32'h1);
    check("t5_qdata", 32'(o_q_data), 32'h2);
    set_req(1, 1'b0, 2'b00, 16'h0);
    @(negedge i_CLK);
    check("t5_rsp_valid", 32'(o_rsp_valid), 32'h1);
    check("t5_rsp_id",    32'(o_rsp_id),    32'h1);
    check("t5_rsp_data",  32'(o_rsp_data),  32'h9);
    @(negedge i_CLK);
    @(negedge i_CLK);
    #1;
    check("t5_full_blocks", 32'(o_req_ready), 32'h0);

    // 6: reset aborts a pop before its response and restarts the pointer
    clear_reqs();
    i_q_full = 1'b0; i_q_empty = 1'b0; i_q_data = 16'h0044;
    set_req(1, 1'b1, 2'b10, 16'h0);
    do_reset();
    #1;
    check("t6_ready", 32'(o_req_ready), 32'h2);
    @(negedge i_CLK);
    check("t6_read", 32'(o_q_read), 32'h1);
    clear_reqs();
    i_RSTn = 1'b0;
    #1;
    check("t6_read_clr", 32'(o_q_read),    32'h0);
    check("t6_rsp_clr",  32'(o_rsp_valid), 32'h0);
    @(negedge i_CLK);
    check("t6_rsp_none", 32'(o_rsp_valid), 32'h0);
    set_req(0, 1'b1, 2'b10, 16'h0);
    set_req(2, 1'b1, 2'b10, 16'h0);
    @(negedge i_CLK);
    i_RSTn = 1'b1;
    #1;
    check("t6_ptr_restart", 32'(o_req_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
